// File: rtl/alu_pkg.sv
// Shared ALU definitions: bitwise opcode map and skid-buffer state encoding.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_op_sel.sv
// Bitwise function select over the word gates.
// Latency: combinational. Backpressure: none (no handshake at this level).
// NAND/NOR reuse the AND/OR gates and invert at the mux.
module bitwise_op_sel
  import alu_pkg::*;
#(
  parameter int w = 64
) (
  input  logic [2:0]   op,
  input  logic [w-1:0] in_0,
  input  logic [w-1:0] in_1,
  output logic [w-1:0] res
);

  logic [w-1:0] and_y, or_y, xor_y, xnor_y;

  and_wordgate  #(.w(w)) u_and  (.a(in_0), .b(in_1), .y(and_y));
  or_wordgate   #(.w(w)) u_or   (.a(in_0), .b(in_1), .y(or_y));
  xor_wordgate  #(.w(w)) u_xor  (.a(in_0), .b(in_1), .y(xor_y));
  xnor_wordgate #(.w(w)) u_xnor (.a(in_0), .b(in_1), .y(xnor_y));

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = and_y;
      OP_OR:   res = or_y;
      OP_XOR:  res = xor_y;
      OP_XNOR: res = xnor_y;
      OP_NAND: res = ~and_y;
      OP_NOR:  res = ~or_y;
      OP_NOT:  res = ~in_0;
      OP_PASS: res = in_1;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_wordgate.sv
// Word-wide two-input gates: purely combinational, zero latency, no flow control.
module and_wordgate #(parameter int w = 64) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] y
);
  assign y = a & b;
endmodule

module or_wordgate #(parameter int w = 64) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] y
);
  assign y = a | b;
endmodule

module xor_wordgate #(parameter int w = 64) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] y
);
  assign y = a ^ b;
endmodule

module xnor_wordgate #(parameter int w = 64) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] y
);
  assign y = ~(a ^ b);
endmodule

// File: rtl/bitwise_stage.sv
// Registered bitwise-logic stage with 2-entry skid buffer; optional zero/parity flags (LOGIC_FLAGS_EN).
// Latency: 1 cycle accept-to-result. Backpressure: in_ready is a flop, low only while both M and S hold results.
// S stores computed results, so a stall never needs the operands again.
module bitwise_stage
  import alu_pkg::*;
#(
  parameter int w = 64
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic signed [w-1:0] in_0,
  input  logic signed [w-1:0] in_1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [w-1:0] result
`ifdef LOGIC_FLAGS_EN
  ,
  output logic                zero,
  output logic                parity
`endif
);

  state_t       state, state_nxt;
  logic [w-1:0] res, m_dat, s_dat;
  logic         accept, consume;
  logic         load_m, load_s, move_s;

  bitwise_op_sel #(.w(w)) u_sel (
    .op   (op),
    .in_0 (in_0),
    .in_1 (in_1),
    .res  (res)
  );

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !consume)      state_nxt = ST_TWO;
        else if (!accept && consume) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (consume) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state != ST_EMPTY);
    load_m    = 1'b0;
    load_s    = 1'b0;
    move_s    = 1'b0;
    case (state)
      ST_EMPTY: load_m = accept;
      ST_ONE: begin
        load_m = accept && consume;
        load_s = accept && !consume;
      end
      ST_TWO: begin
        load_m = consume;
        move_s = consume;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      in_ready <= 1'b1;
      m_dat    <= '0;
      s_dat    <= '0;
    end else begin
      in_ready <= (state_nxt != ST_TWO);
      if (load_m) m_dat <= move_s ? s_dat : res;
      if (load_s) s_dat <= res;
    end
  end

  assign result = m_dat;

`ifdef LOGIC_FLAGS_EN
  logic zero_s, parity_s;

  // Flags travel with their result so they stay aligned across the S->M move.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      zero     <= 1'b1;
      parity   <= 1'b0;
      zero_s   <= 1'b1;
      parity_s <= 1'b0;
    end else begin
      if (load_m) begin
        zero   <= move_s ? zero_s   : ~|res;
        parity <= move_s ? parity_s : ^res;
      end
      if (load_s) begin
        zero_s   <= ~|res;
        parity_s <= ^res;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_stage.sv
// Directed bench for bitwise_stage at w=8 and w=16.
module tb_bitwise_stage;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        in_valid, out_ready, in_ready, out_valid;
  logic [2:0]  op;
  logic [7:0]  in_0, in_1, result;
  logic        v16, rdy16, ordy16, ov16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, r16;
`ifdef LOGIC_FLAGS_EN
  logic        zero, parity, zero16, parity16;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitwise_stage #(.w(8)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in_0(in_0), .in_1(in_1), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
`ifdef LOGIC_FLAGS_EN
    , .zero(zero), .parity(parity)
`endif
  );

  bitwise_stage #(.w(16)) dut16 (
    .clk(clk), .rst_b(rst_b), .in_valid(v16), .in_ready(rdy16),
    .op(op16), .in_0(a16), .in_1(b16), .out_valid(ov16),
    .out_ready(ordy16), .result(r16)
`ifdef LOGIC_FLAGS_EN
    , .zero(zero16), .parity(parity16)
`endif
  );

  task automatic test_reset;
    rst_b = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'b000; in_0 = 8'h00; in_1 = 8'h00;
    v16 = 1'b0; ordy16 = 1'b0; op16 = 3'b000; a16 = 16'h0; b16 = 16'h0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    rst_b = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL idle_result got=%h exp=00", result); end
`ifdef LOGIC_FLAGS_EN
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL idle_zero got=%b exp=1", zero); end
    n_cmp++; if (parity !== 1'b0) begin n_bad++; $display("FAIL idle_parity got=%b exp=0", parity); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [4];
    logic [7:0] exp [4];
    ops = '{3'b011, 3'b000, 3'b001, 3'b110};
    exp = '{8'h55, 8'h05, 8'hAF, 8'h5A};
    out_ready = 1'b1; in_0 = 8'hA5; in_1 = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op = ops[i];
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
      n_cmp++; if (result !== exp[i]) begin n_bad++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, result, exp[i]); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; in_valid = 1'b1;
    op = 3'b010; in_0 = 8'hA5; in_1 = 8'h0F;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
    n_cmp++; if (result !== 8'hAA) begin n_bad++; $display("FAIL bp_first got=%h exp=aa", result); end
    op = 3'b111; in_1 = 8'h3C;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_two got=%b exp=0", in_ready); end
    n_cmp++; if (result !== 8'hAA) begin n_bad++; $display("FAIL bp_hold got=%h exp=aa", result); end
    // Offered while full: must not be taken.
    op = 3'b000; in_1 = 8'hFF;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_stall got=%b exp=0", in_ready); end
    n_cmp++; if (result !== 8'hAA) begin n_bad++; $display("FAIL bp_stall got=%h exp=aa", result); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (result !== 8'h3C) begin n_bad++; $display("FAIL bp_second got=%h exp=3c", result); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
`ifdef LOGIC_FLAGS_EN
    n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL bp_zero got=%b exp=0", zero); end
`endif
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reload;
    out_ready = 1'b0; in_valid = 1'b1;
    op = 3'b000; in_0 = 8'hA5; in_1 = 8'h0F;
    @(negedge clk);
    n_cmp++; if (result !== 8'h05) begin n_bad++; $display("FAIL reload_first got=%h exp=05", result); end
    out_ready = 1'b1; op = 3'b001;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL reload_valid got=%b exp=1", out_valid); end
    n_cmp++; if (result !== 8'hAF) begin n_bad++; $display("FAIL reload_result got=%h exp=af", result); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reload_ready got=%b exp=1", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reload_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1;
    op = 3'b010; in_0 = 8'hA5; in_1 = 8'h0F;
    @(negedge clk);
    op = 3'b110;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_full got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    rst_b = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
    n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL mid_result got=%h exp=00", result); end
    #1;
    rst_b = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_width16;
    logic [2:0]  ops [2];
    logic [15:0] bs  [2];
    logic [15:0] exp [2];
    logic        pexp [2];
    ops = '{3'b011, 3'b000};
    bs  = '{16'h7FFF, 16'hFFFF};
    exp = '{16'h0000, 16'h8000};
    pexp = '{1'b0, 1'b1};
    ordy16 = 1'b1; a16 = 16'h8000;
    for (int i = 0; i < 2; i++) begin
      v16 = 1'b1; op16 = ops[i]; b16 = bs[i];
      @(negedge clk);
      n_cmp++; if (ov16 !== 1'b1) begin n_bad++; $display("FAIL w16_valid[%0d] got=%b exp=1", i, ov16); end
      n_cmp++; if (r16 !== exp[i]) begin n_bad++; $display("FAIL w16_result[%0d] got=%h exp=%h", i, r16, exp[i]); end
`ifdef LOGIC_FLAGS_EN
      n_cmp++; if (zero16 !== (exp[i] == 16'h0)) begin n_bad++; $display("FAIL w16_zero[%0d] got=%b", i, zero16); end
      n_cmp++; if (parity16 !== pexp[i]) begin n_bad++; $display("FAIL w16_parity[%0d] got=%b exp=%b", i, parity16, pexp[i]); end
`endif
    end
    v16 = 1'b0;
    @(negedge clk);
    n_cmp++; if (ov16 !== 1'b0) begin n_bad++; $display("FAIL w16_drain got=%b exp=0", ov16); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_backpressure;
    test_reload;
    test_reset_mid;
    test_width16;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
